// File: rtl/enemy_hit_scheduler.sv
// enemy_hit_scheduler: time-multiplexes one bullet/enemy hitbox comparator over all
// pairs once per frame, tracking enemy health, consumed bullets and explosion timers.
`default_nettype none

module enemy_hit_scheduler #(
  parameter int NUM_ENEMY   = 4,
  parameter int NUM_BULLET  = 4,
  parameter int BOOM_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic [10*NUM_ENEMY-1:0] enemy_x,
  input  logic [10*NUM_ENEMY-1:0] enemy_y,
  input  logic [NUM_ENEMY-1:0]    enemy_en,
  input  logic [10*NUM_BULLET-1:0] bullet_x,
  input  logic [10*NUM_BULLET-1:0] bullet_y,
  input  logic [NUM_BULLET-1:0]   bullet_en,
  input  logic [NUM_ENEMY-1:0]    enemy_spawn,
  input  logic [2:0]              spawn_health,
  output logic [3*NUM_ENEMY-1:0]  enemy_health,
  output logic [NUM_BULLET-1:0]   bullet_kill,
  output logic [NUM_ENEMY-1:0]    boom,
  output logic                    kill_pulse,
  output logic                    scan_busy,
  output logic                    overrun
);

  localparam int EW = (NUM_ENEMY  > 1) ? $clog2(NUM_ENEMY)  : 1;
  localparam int BW = (NUM_BULLET > 1) ? $clog2(NUM_BULLET) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                   state;
  logic [10*NUM_ENEMY-1:0]  ex_s, ey_s;
  logic [NUM_ENEMY-1:0]     een_s;
  logic [10*NUM_BULLET-1:0] bx_s, by_s;
  logic [NUM_BULLET-1:0]    ben_s;
  logic [EW-1:0]            e_idx;
  logic [BW-1:0]            b_idx;
  logic [NUM_BULLET-1:0]    consumed;
  logic [2:0]               health   [NUM_ENEMY];
  logic [3:0]               boom_cnt [NUM_ENEMY];

  logic [10:0] ex11, ey11, bx11, by11;
  logic        hitbox;
  logic        qual_hit;
  logic        last_hp;

  // Coordinates widened to 11 bits so the +offset comparisons cannot wrap.
  assign ex11 = {1'b0, ex_s[10*int'(e_idx) +: 10]};
  assign ey11 = {1'b0, ey_s[10*int'(e_idx) +: 10]};
  assign bx11 = {1'b0, bx_s[10*int'(b_idx) +: 10]};
  assign by11 = {1'b0, by_s[10*int'(b_idx) +: 10]};

  assign hitbox = (bx11 + 11'd10 >= ex11) && (bx11 < ex11 + 11'd50) &&
                  (by11 + 11'd50 >  ey11) && (by11 < ey11 + 11'd40);

  assign qual_hit = (state == SCAN) && een_s[e_idx] && ben_s[b_idx] &&
                    !consumed[b_idx] && (health[e_idx] != 3'd0) && hitbox;

  assign last_hp = (health[e_idx] == 3'd1) && !enemy_spawn[e_idx];

  for (genvar g = 0; g < NUM_ENEMY; g++) begin : g_health
    assign enemy_health[3*g +: 3] = health[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ex_s        <= '0;
      ey_s        <= '0;
      een_s       <= '0;
      bx_s        <= '0;
      by_s        <= '0;
      ben_s       <= '0;
      e_idx       <= '0;
      b_idx       <= '0;
      consumed    <= '0;
      bullet_kill <= '0;
      boom        <= '0;
      kill_pulse  <= 1'b0;
      scan_busy   <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_ENEMY; i++) begin
        health[i]   <= 3'd0;
        boom_cnt[i] <= 4'd0;
      end
    end else begin
      bullet_kill <= '0;
      kill_pulse  <= qual_hit && last_hp;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            ex_s      <= enemy_x;
            ey_s      <= enemy_y;
            een_s     <= enemy_en;
            bx_s      <= bullet_x;
            by_s      <= bullet_y;
            ben_s     <= bullet_en;
            consumed  <= '0;
            e_idx     <= '0;
            b_idx     <= '0;
            scan_busy <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (frame_tick) overrun <= 1'b1;
          if (qual_hit) begin
            consumed[b_idx]    <= 1'b1;
            bullet_kill[b_idx] <= 1'b1;
          end
          if (int'(b_idx) == NUM_BULLET - 1) begin
            b_idx <= '0;
            if (int'(e_idx) == NUM_ENEMY - 1) begin
              e_idx     <= '0;
              scan_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              e_idx <= e_idx + 1'b1;
            end
          end else begin
            b_idx <= b_idx + 1'b1;
          end
        end
      endcase

      // Later assignments take priority: countdown < kill < spawn.
      for (int i = 0; i < NUM_ENEMY; i++) begin
        if (frame_tick && (boom_cnt[i] != 4'd0)) begin
          boom_cnt[i] <= boom_cnt[i] - 4'd1;
          if (boom_cnt[i] == 4'd1) boom[i] <= 1'b0;
        end
        if (qual_hit && (int'(e_idx) == i) && !enemy_spawn[i]) begin
          health[i] <= health[i] - 3'd1;
          if (health[i] == 3'd1) begin
            boom[i]     <= 1'b1;
            boom_cnt[i] <= 4'(BOOM_FRAMES);
          end
        end
        if (enemy_spawn[i]) begin
          health[i]   <= spawn_health;
          boom[i]     <= 1'b0;
          boom_cnt[i] <= 4'd0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/enemy_hit_scheduler.md
Name: enemy_hit_scheduler

Overview:
- Sequences bullet-vs-enemy hit testing for the shooter playfield (640x480, 10-bit coordinates).
- A single shared hitbox comparator is time-multiplexed over NUM_ENEMY enemy slots × NUM_BULLET player bullets, one pair per clock, once per frame.
- Owns per-enemy health, kills consumed bullets, and times each enemy's explosion (boom) display.
- Sits between the bullet/enemy position generators and the renderer/score logic.

Parameters:
- NUM_ENEMY, 4, number of enemy slots (1..8).
- NUM_BULLET, 4, number of player bullet slots (1..8).
- BOOM_FRAMES, 8, frames boom stays asserted after a kill (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame; starts a scan.
- enemy_x  in  10*NUM_ENEMY  packed enemy x, slot i at [10i+9:10i].
- enemy_y  in  10*NUM_ENEMY  packed enemy y (playfield coordinates).
- enemy_en  in  NUM_ENEMY  enemy slot active.
- bullet_x  in  10*NUM_BULLET  packed bullet x.
- bullet_y  in  10*NUM_BULLET  packed bullet y.
- bullet_en  in  NUM_BULLET  bullet in flight.
- enemy_spawn  in  NUM_ENEMY  one-cycle pulse; reload slot health.
- spawn_health  in  3  health value loaded on spawn.
- enemy_health  out  3*NUM_ENEMY  current health per slot.
- bullet_kill  out  NUM_BULLET  one-cycle pulse; bullet consumed by a hit.
- boom  out  NUM_ENEMY  explosion display active per slot.
- kill_pulse  out  1  one-cycle pulse when any enemy health reaches 0.
- scan_busy  out  1  high while a scan is in progress.
- overrun  out  1  sticky; frame_tick arrived while scan_busy.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all health=0, boom=0, boom counters=0, bullet_kill=0, kill_pulse=0, scan_busy=0, overrun=0, consumed mask=0.
- FSM states:
  - IDLE: on frame_tick, snapshot every x/y/en input into registers, clear consumed mask, set e=0 and b=0, go to SCAN. scan_busy rises on the same edge.
  - SCAN: evaluate pair (e,b) from the snapshots, one pair per cycle. Bullet index is inner: b increments; on b=NUM_BULLET-1, b wraps to 0 and e increments. After pair (NUM_ENEMY-1, NUM_BULLET-1), go to IDLE with scan_busy=0. Scan length is exactly NUM_ENEMY*NUM_BULLET cycles.
  - frame_tick during SCAN: ignored (scan not restarted), overrun<=1.
- Hitbox, computed in 11-bit unsigned so nothing underflows. Hit iff all hold:
  - bx+10 >= ex
  - bx < ex+50
  - by+50 > ey
  - by < ey+40
- Qualified hit, all required:
  - snapshot enemy_en[e]=1
  - snapshot bullet_en[b]=1
  - consumed[b]=0
  - health[e]>0
  - hitbox true
- On qualified hit, registered at the evaluating edge (latency 1 cycle from pair evaluation):
  - health[e] decrements by 1.
  - consumed[b]<=1, so a bullet hits at most one enemy per scan; lower enemy index wins.
  - bullet_kill[b] pulses for 1 cycle.
  - If health[e] was 1: kill_pulse pulses, boom[e]<=1, boom counter[e]<=BOOM_FRAMES.
- Boom countdown:
  - On each frame_tick, every nonzero boom counter decrements.
  - boom[e] drops on the edge where its counter reaches 0.
  - Boom is independent of FSM state.
- Spawn:
  - enemy_spawn[i] in any state sets health[i]<=spawn_health, boom[i]<=0, counter[i]<=0.
  - If it coincides with a qualified hit on the same slot, spawn wins: no decrement, but the bullet is still consumed and killed.
  - spawn_health=0 leaves the slot dead with no boom.
- Health never wraps: decrement only occurs from values >0.
- Multiple spawn bits may be set in the same cycle; each slot is handled independently.
- Reset mid-scan: immediate return to IDLE with all reset values; no pending bullet_kill survives.
- Inputs changing mid-scan have no effect until the next frame_tick (snapshot semantics).

Test Plan:
- Single hit: spawn slot0 health=2, enemy0 (100,200) en, bullet0 (120,220) en, frame_tick → one cycle after pair (0,0) evaluates: bullet_kill=0001, health0=1, boom0=0, kill_pulse=0; scan_busy high exactly 16 cycles.
- Kill and boom: health0=1, same geometry → kill_pulse once, boom0=1. boom0 stays high for 8 frame_ticks, then drops on the 8th tick after the kill.
- Boundaries (enemy at (100,200)):
  - bx=90 hits; bx=89 misses.
  - bx=149 hits; bx=150 misses.
  - by=151 hits; by=150 misses.
  - by=239 hits; by=240 misses.
  - Underflow case: enemy at (5,5), bullet at (0,0) → hit.
- Shared bullet: enemies 0 and 1 both overlap bullet2 → only health0 decrements; single bullet_kill[2] pulse; health1 unchanged.
- Overrun: frame_tick pulsed 5 cycles into a scan → scan completes at cycle 16 without restart, overrun=1 and stays 1 until reset.
- Spawn/reset collisions:
  - enemy_spawn[0] with spawn_health=3 in the same cycle as a hit on slot0 → health0=3 and bullet still killed.
  - rst asserted mid-scan → all outputs return to zero within the reset assertion.
